// File: rtl/lct_to_gem_pad_rom_pkg.sv
// Shared constants and LUT helpers for the reverse ME11 CSC->GEM map.
// The xky->pad and wg->roll LUT contents are generated by functions in this package.
// Each ROM instance selects its table through a ROM_KIND code.
package lct_to_gem_pad_rom_pkg;

    localparam int MXXKYB   = 10;
    localparam int WIREBITS = 7;
    localparam int PADBITS  = 8;

    localparam logic [6:0] MAXWIRE    = 7'd47;
    localparam logic [7:0] MAXPAD     = 8'd191;
    localparam logic [9:0] MAXXKYME1B = 10'd511;
    localparam logic [9:0] MINXKYME1A = 10'd512;
    localparam logic [9:0] MAXXKYME1A = 10'd895;
    localparam logic [7:0] NOCOV      = 8'hFF;

    // LUT selectors; these replace the pad/roll even/odd table files.
    localparam int ROM_PAD_EVEN  = 0;
    localparam int ROM_PAD_ODD   = 1;
    localparam int ROM_ROLL_EVEN = 2;
    localparam int ROM_ROLL_ODD  = 3;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_SEQ1 = 1'b1;

    // Clamp an extended-width address into [lo,hi]; 'under' flags a subtraction underflow.
    function automatic logic [9:0] clamp_val(input logic [10:0] v, input logic under,
                                             input logic [9:0] lo, input logic [9:0] hi);
        logic [9:0] r;
        if (under) r = lo;
        else if (v > {1'b0, hi}) r = hi;
        else if (v < {1'b0, lo}) r = lo;
        else r = 10'(v);
        return r;
    endfunction

    // Even-chamber pad: ME1b spreads 512 xky over 192 pads, ME1a uses 2 xky per pad.
    function automatic logic [7:0] pad_even_word(input logic [9:0] x);
        logic [10:0] x3;
        logic [9:0]  rel;
        logic [7:0]  w;
        x3  = {1'b0, x} + {x, 1'b0};
        rel = x - MINXKYME1A;
        if (x <= MAXXKYME1B) w = 8'(x3 >> 3);
        else if (x <= MAXXKYME1A) w = 8'(rel >> 1);
        else w = NOCOV;
        return w;
    endfunction

    // Odd-chamber pad: mirrored (decreasing) map, with an uncovered strip at the ME1b edge.
    function automatic logic [7:0] pad_odd_word(input logic [9:0] x);
        logic [7:0] pe;
        logic [7:0] w;
        pe = pad_even_word(x);
        if ((x >= 10'd504) && (x <= MAXXKYME1B)) w = NOCOV;
        else if (pe == NOCOV) w = NOCOV;
        else w = MAXPAD - pe;
        return w;
    endfunction

    // Even-chamber roll: six wiregroups per GEM roll.
    function automatic logic [2:0] roll_even_word(input logic [6:0] wg);
        logic [2:0] r;
        if (wg > MAXWIRE) r = 3'd7;
        else r = 3'(wg / 7'd6);
        return r;
    endfunction

    // LUT contents indexed by table kind.
    function automatic logic [7:0] rom_word(input int kind, input logic [9:0] adr);
        logic [7:0] w;
        case (kind)
            ROM_PAD_EVEN:  w = pad_even_word(adr);
            ROM_PAD_ODD:   w = pad_odd_word(adr);
            ROM_ROLL_EVEN: w = {5'd0, roll_even_word(adr[6:0])};
            ROM_ROLL_ODD:  w = {5'd0, 3'd7 - roll_even_word(adr[6:0])};
            default:       w = NOCOV;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/lct_to_gem_pad_rom_if.sv
// LCT pair request / GEM window result bundle for lct_to_gem_pad_rom.
interface lct_to_gem_pad_rom_if;
    import lct_to_gem_pad_rom_pkg::*;

    logic                evenchamber;
    logic [4:0]          lct_deltahs;
    logic [2:0]          lct_deltawire;
    logic                lct0_vpf;
    logic                lct1_vpf;
    logic [WIREBITS-1:0] lct0_keywire;
    logic [WIREBITS-1:0] lct1_keywire;
    logic [MXXKYB-1:0]   lct0_xky;
    logic [MXXKYB-1:0]   lct1_xky;
    logic                lct_ready;
    logic                gem_vpf;
    logic                gem_idx;
    logic [PADBITS-1:0]  gem_pad_lo;
    logic [PADBITS-1:0]  gem_pad_hi;
    logic [2:0]          gem_roll_lo;
    logic [2:0]          gem_roll_hi;
    logic                gem_me1a;
    logic                gem_nocov;

    modport master (
        output evenchamber, lct_deltahs, lct_deltawire,
               lct0_vpf, lct1_vpf, lct0_keywire, lct1_keywire, lct0_xky, lct1_xky,
        input  lct_ready, gem_vpf, gem_idx, gem_pad_lo, gem_pad_hi,
               gem_roll_lo, gem_roll_hi, gem_me1a, gem_nocov
    );

    modport slave (
        input  evenchamber, lct_deltahs, lct_deltawire,
               lct0_vpf, lct1_vpf, lct0_keywire, lct1_keywire, lct0_xky, lct1_xky,
        output lct_ready, gem_vpf, gem_idx, gem_pad_lo, gem_pad_hi,
               gem_roll_lo, gem_roll_hi, gem_me1a, gem_nocov
    );

endinterface

// File: rtl/lct_to_gem_pad_rom_rom_xky_pad.sv
// Dual-port synchronous-read LUT ROM (one cycle read latency on both ports).
import lct_to_gem_pad_rom_pkg::*;

module rom_xky_pad #(
    parameter int ROM_KIND = ROM_PAD_EVEN,
    parameter int ADRBITS  = 10,
    parameter int DATABITS = 8
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [ADRBITS-1:0]  adr_a,
    input  logic [ADRBITS-1:0]  adr_b,
    output logic [DATABITS-1:0] dout_a,
    output logic [DATABITS-1:0] dout_b
);

    logic [DATABITS-1:0] dout_a_d, dout_a_q;
    logic [DATABITS-1:0] dout_b_d, dout_b_q;

    // Table lookup for both ports.
    always_comb begin
        dout_a_d = DATABITS'(rom_word(ROM_KIND, MXXKYB'(adr_a)));
        dout_b_d = DATABITS'(rom_word(ROM_KIND, MXXKYB'(adr_b)));
    end

    // Registered read data.
    always_ff @(posedge clock) begin
        if (reset) begin
            dout_a_q <= {DATABITS{1'b0}};
            dout_b_q <= {DATABITS{1'b0}};
        end else begin
            dout_a_q <= dout_a_d;
            dout_b_q <= dout_b_d;
        end
    end

    assign dout_a = dout_a_q;
    assign dout_b = dout_b_q;

endmodule

// File: rtl/lct_to_gem_pad_rom.sv
// Reverse ME11 GEM-CSC map: projects up to two LCTs per BX into GEM pad/roll windows.
// LCT0/LCT1 share one ROM set and are serialized (issue -> result in 2 cycles).
// Optional macro LCT_ME1A_ROLL7_FORCE_EN: ME1a LCTs report roll window 7..7.
import lct_to_gem_pad_rom_pkg::*;

module lct_to_gem_pad_rom (
    input  logic                    clock,
    input  logic                    reset,
    lct_to_gem_pad_rom_if.slave     bus
);

    logic [0:0]          state_d, state_q;
    logic                lct_ready_d, lct_ready_q;
    logic [WIREBITS-1:0] hold_wire_d, hold_wire_q;
    logic [MXXKYB-1:0]   hold_xky_d, hold_xky_q;
    logic                accept_s, iss_vld_s, iss_idx_s, me1a_s;
    logic [WIREBITS-1:0] iss_wire_s, wglo_s, wghi_s;
    logic [MXXKYB-1:0]   iss_xky_s, xkylo_s, xkyhi_s, reg_min_s, reg_max_s;
    logic [10:0]         xky_lo_w_s, xky_hi_w_s, wg_lo_w_s, wg_hi_w_s, dhs4_s;
    logic                s1_vld_d, s1_vld_q, s1_idx_d, s1_idx_q;
    logic                s1_even_d, s1_even_q, s1_me1a_d, s1_me1a_q;
    logic [7:0]          pad_e_a_s, pad_e_b_s, pad_o_a_s, pad_o_b_s, pa_s, pb_s, plo_s, phi_s;
    logic [2:0]          roll_e_a_s, roll_e_b_s, roll_o_a_s, roll_o_b_s, ra_s, rb_s, rlo_s, rhi_s;
    logic                nocov_s;
    logic                gem_vpf_d, gem_vpf_q, gem_idx_d, gem_idx_q;
    logic                gem_me1a_d, gem_me1a_q, gem_nocov_d, gem_nocov_q;
    logic [7:0]          gem_pad_lo_d, gem_pad_lo_q, gem_pad_hi_d, gem_pad_hi_q;
    logic [2:0]          gem_roll_lo_d, gem_roll_lo_q, gem_roll_hi_d, gem_roll_hi_q;

    // Accept/serialize FSM: pick the LCT issued this cycle and park LCT1 of a pair.
    always_comb begin
        state_d     = state_q;
        hold_wire_d = hold_wire_q;
        hold_xky_d  = hold_xky_q;
        iss_vld_s   = 1'b0;
        iss_idx_s   = 1'b0;
        iss_wire_s  = bus.lct0_keywire;
        iss_xky_s   = bus.lct0_xky;
        accept_s    = (bus.lct0_vpf | bus.lct1_vpf) & lct_ready_q;
        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    iss_vld_s = 1'b1;
                    if (bus.lct0_vpf) begin
                        if (bus.lct1_vpf) begin
                            hold_wire_d = bus.lct1_keywire;
                            hold_xky_d  = bus.lct1_xky;
                            state_d     = ST_SEQ1;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        iss_idx_s  = 1'b1;
                        iss_wire_s = bus.lct1_keywire;
                        iss_xky_s  = bus.lct1_xky;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SEQ1: begin
                iss_vld_s  = 1'b1;
                iss_idx_s  = 1'b1;
                iss_wire_s = hold_wire_q;
                iss_xky_s  = hold_xky_q;
                state_d    = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        lct_ready_d = (state_d == ST_IDLE);
    end

    // Window addresses, clamped to the LCT's own ME1a/ME1b region and the wiregroup range.
    always_comb begin
        me1a_s     = (iss_xky_s >= MINXKYME1A);
        reg_min_s  = me1a_s ? MINXKYME1A : 10'd0;
        reg_max_s  = me1a_s ? MAXXKYME1A : MAXXKYME1B;
        dhs4_s     = {4'd0, bus.lct_deltahs, 2'b00};
        xky_lo_w_s = {1'b0, iss_xky_s} - dhs4_s;
        xky_hi_w_s = {1'b0, iss_xky_s} + dhs4_s;
        wg_lo_w_s  = {4'd0, iss_wire_s} - {8'd0, bus.lct_deltawire};
        wg_hi_w_s  = {4'd0, iss_wire_s} + {8'd0, bus.lct_deltawire};
        xkylo_s    = clamp_val(xky_lo_w_s, xky_lo_w_s[10], reg_min_s, reg_max_s);
        xkyhi_s    = clamp_val(xky_hi_w_s, 1'b0, reg_min_s, reg_max_s);
        wglo_s     = 7'(clamp_val(wg_lo_w_s, wg_lo_w_s[10], 10'd0, {3'd0, MAXWIRE}));
        wghi_s     = 7'(clamp_val(wg_hi_w_s, 1'b0, 10'd0, {3'd0, MAXWIRE}));
        s1_vld_d   = iss_vld_s;
        s1_idx_d   = iss_idx_s;
        s1_even_d  = bus.evenchamber;
        s1_me1a_d  = me1a_s;
    end

    rom_xky_pad #(.ROM_KIND(ROM_PAD_EVEN), .ADRBITS(MXXKYB), .DATABITS(PADBITS)) u_pad_even (
        .clock(clock), .reset(reset), .adr_a(xkylo_s), .adr_b(xkyhi_s), .dout_a(pad_e_a_s), .dout_b(pad_e_b_s));
    rom_xky_pad #(.ROM_KIND(ROM_PAD_ODD), .ADRBITS(MXXKYB), .DATABITS(PADBITS)) u_pad_odd (
        .clock(clock), .reset(reset), .adr_a(xkylo_s), .adr_b(xkyhi_s), .dout_a(pad_o_a_s), .dout_b(pad_o_b_s));
    rom_xky_pad #(.ROM_KIND(ROM_ROLL_EVEN), .ADRBITS(WIREBITS), .DATABITS(3)) u_roll_even (
        .clock(clock), .reset(reset), .adr_a(wglo_s), .adr_b(wghi_s), .dout_a(roll_e_a_s), .dout_b(roll_e_b_s));
    rom_xky_pad #(.ROM_KIND(ROM_ROLL_ODD), .ADRBITS(WIREBITS), .DATABITS(3)) u_roll_odd (
        .clock(clock), .reset(reset), .adr_a(wglo_s), .adr_b(wghi_s), .dout_a(roll_o_a_s), .dout_b(roll_o_b_s));

    // Chamber mux, min/max sort (odd chambers map decreasingly), coverage check, output load.
    always_comb begin
        pa_s    = s1_even_q ? pad_e_a_s  : pad_o_a_s;
        pb_s    = s1_even_q ? pad_e_b_s  : pad_o_b_s;
        ra_s    = s1_even_q ? roll_e_a_s : roll_o_a_s;
        rb_s    = s1_even_q ? roll_e_b_s : roll_o_b_s;
        nocov_s = (pa_s == NOCOV) | (pb_s == NOCOV);
        if (nocov_s) begin
            plo_s = 8'd0;
            phi_s = 8'd0;
        end else begin
            plo_s = (pa_s < pb_s) ? pa_s : pb_s;
            phi_s = (pa_s < pb_s) ? pb_s : pa_s;
            plo_s = (plo_s > MAXPAD) ? MAXPAD : plo_s;
            phi_s = (phi_s > MAXPAD) ? MAXPAD : phi_s;
        end
`ifdef LCT_ME1A_ROLL7_FORCE_EN
        if (s1_me1a_q) begin
            rlo_s = 3'd7;
            rhi_s = 3'd7;
        end else begin
            rlo_s = (ra_s < rb_s) ? ra_s : rb_s;
            rhi_s = (ra_s < rb_s) ? rb_s : ra_s;
        end
`else
        rlo_s = (ra_s < rb_s) ? ra_s : rb_s;
        rhi_s = (ra_s < rb_s) ? rb_s : ra_s;
`endif
        gem_vpf_d = s1_vld_q;
        if (s1_vld_q) begin
            gem_idx_d     = s1_idx_q;
            gem_pad_lo_d  = plo_s;
            gem_pad_hi_d  = phi_s;
            gem_roll_lo_d = rlo_s;
            gem_roll_hi_d = rhi_s;
            gem_me1a_d    = s1_me1a_q;
            gem_nocov_d   = nocov_s;
        end else begin
            gem_idx_d     = gem_idx_q;
            gem_pad_lo_d  = gem_pad_lo_q;
            gem_pad_hi_d  = gem_pad_hi_q;
            gem_roll_lo_d = gem_roll_lo_q;
            gem_roll_hi_d = gem_roll_hi_q;
            gem_me1a_d    = gem_me1a_q;
            gem_nocov_d   = gem_nocov_q;
        end
    end

    // State, hold register, pipeline tags and result registers; reset drops all in-flight work.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            lct_ready_q   <= 1'b1;
            hold_wire_q   <= 7'd0;
            hold_xky_q    <= 10'd0;
            s1_vld_q      <= 1'b0;
            s1_idx_q      <= 1'b0;
            s1_even_q     <= 1'b0;
            s1_me1a_q     <= 1'b0;
            gem_vpf_q     <= 1'b0;
            gem_idx_q     <= 1'b0;
            gem_pad_lo_q  <= 8'd0;
            gem_pad_hi_q  <= 8'd0;
            gem_roll_lo_q <= 3'd0;
            gem_roll_hi_q <= 3'd0;
            gem_me1a_q    <= 1'b0;
            gem_nocov_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            lct_ready_q   <= lct_ready_d;
            hold_wire_q   <= hold_wire_d;
            hold_xky_q    <= hold_xky_d;
            s1_vld_q      <= s1_vld_d;
            s1_idx_q      <= s1_idx_d;
            s1_even_q     <= s1_even_d;
            s1_me1a_q     <= s1_me1a_d;
            gem_vpf_q     <= gem_vpf_d;
            gem_idx_q     <= gem_idx_d;
            gem_pad_lo_q  <= gem_pad_lo_d;
            gem_pad_hi_q  <= gem_pad_hi_d;
            gem_roll_lo_q <= gem_roll_lo_d;
            gem_roll_hi_q <= gem_roll_hi_d;
            gem_me1a_q    <= gem_me1a_d;
            gem_nocov_q   <= gem_nocov_d;
        end
    end

    assign bus.lct_ready   = lct_ready_q;
    assign bus.gem_vpf     = gem_vpf_q;
    assign bus.gem_idx     = gem_idx_q;
    assign bus.gem_pad_lo  = gem_pad_lo_q;
    assign bus.gem_pad_hi  = gem_pad_hi_q;
    assign bus.gem_roll_lo = gem_roll_lo_q;
    assign bus.gem_roll_hi = gem_roll_hi_q;
    assign bus.gem_me1a    = gem_me1a_q;
    assign bus.gem_nocov   = gem_nocov_q;

endmodule
